floo_wide_link_tx: RTL and testbench
====================================

// Module: floo_wide_link_tx
// PURPOSE
// - Transmit side of a narrow/wide router link: serializes one wide flit (FlitWidth bits) into
//   NumBeats beats of PhysWidth bits over a valid/ready physical link into the peer router input.
// - Sits between a router/chimney output port and a reduced-width inter-tile link; the peer
//   deserializer reassembles flits using last_o.
// - One-flit buffer with back-to-back support: the next flit is accepted on the last-beat handshake.
// PARAMETERS
// - FlitWidth  default 512  width of one wide flit, in bits
// - PhysWidth  default 128  width of one link beat, in bits; 1 <= PhysWidth <= FlitWidth
// - NumBeats   derived      (FlitWidth + PhysWidth - 1) / PhysWidth; local parameter, not overridable
// - BeatCntW   derived      $clog2(NumBeats), minimum 1
// PORTS
// - clk_i      in   1          clock, rising edge
// - rst_ni     in   1          asynchronous active-low reset
// - valid_i    in   1          flit valid from upstream
// - ready_o    out  1          flit accepted when valid_i && ready_o
// - data_i     in   FlitWidth  flit payload
// - valid_o    out  1          beat valid on link
// - ready_i    in   1          peer accepts beat when valid_o && ready_i
// - data_o     out  PhysWidth  beat payload
// - last_o     out  1          marks the final beat of a flit; valid only with valid_o
// - parity_o   out  1          even parity of data_o (FLOO_WIDE_LINK_TX_PARITY_EN only)
// BEHAVIOUR
// - Clock is clk_i; reset is asynchronous, active-low on rst_ni.
// - Reset: state=IDLE, beat_cnt=0, flit buffer cleared to 0; valid_o=0, last_o=0, data_o=0,
//   ready_o=1, parity_o=0. Reset mid-flit discards the flit; no partial beats follow reset.
// - FSM IDLE: ready_o=1, valid_o=0. On valid_i: register data_i, beat_cnt=0, go to SEND.
// - FSM SEND: valid_o=1. data_o = buffer[beat_cnt*PhysWidth +: PhysWidth], LSB-first.
//   The final beat is zero-padded above bit FlitWidth-1 when FlitWidth % PhysWidth != 0.
// - last_o = (beat_cnt == NumBeats-1) in SEND.
// - On a beat handshake that is not last: beat_cnt increments.
// - On the last-beat handshake: ready_o=1 combinationally (ready_o = last_o && ready_i).
//   - valid_i=1: load new flit, beat_cnt=0, stay in SEND. No idle cycle between flits.
//   - valid_i=0: go to IDLE.
// - ready_o=0 in SEND on every other cycle. No combinational path from valid_i to valid_o.
// - First-beat latency: one cycle after the input handshake.
// - Throughput: one flit per NumBeats cycles under continuous ready_i.
// - NumBeats==1: every beat is last; sustains one flit per cycle in SEND.
// - Backpressure: valid_o, data_o and last_o hold stable while valid_o && !ready_i (AXI-style).
//   valid_o never drops before its handshake.
// - beat_cnt never exceeds NumBeats-1; no wrap past last.
// - Assertions: PhysWidth <= FlitWidth at elaboration.
//   Output stability under stall is checked with a simulation-only assertion.
// CONFIGURATION
// - FLOO_WIDE_LINK_TX_PARITY_EN defined: parity_o = ^data_o, driven combinationally with the beat;
//   0 in IDLE and during reset.
// - Undefined: the parity_o port does not exist; no parity logic is generated.
// TESTING
// - Reset, FlitWidth=512, PhysWidth=128, ready_i=1, one flit 0x..03_02_01_00 pattern
//   -> 4 beats on consecutive cycles, starting 1 cycle after accept, LSB first, last_o on beat 3.
// - Two flits back-to-back with valid_i held, ready_i=1
//   -> 8 contiguous beats; ready_o pulses with beat 3; no bubble between flits.
// - ready_i=0 for 5 cycles on beat 1 -> data_o/last_o frozen, ready_o=0; resumes at beat 1.
// - FlitWidth=300, PhysWidth=128 -> 3 beats; beat 2 bits [127:44] are zero.
// - rst_ni asserted during beat 2 -> outputs at reset values immediately.
//   After release, a new flit starts at beat 0.
// - PARITY_EN, beat data with an odd popcount -> parity_o=1; all-zero beat -> parity_o=0.

Source files
------------

// File: rtl/floo_wide_link_tx.sv
// floo_wide_link_tx: transmit side of a reduced-width inter-tile link.
// Accepts one FlitWidth-bit flit and sends it as NumBeats beats of PhysWidth
// bits, LSB-first, over a valid/ready link; last_o marks the final beat.
// The next flit may be accepted on the last-beat handshake, so a continuous
// stream of flits leaves no idle cycle on the link.
// Optional feature macro: FLOO_WIDE_LINK_TX_PARITY_EN adds parity_o, the even
// parity of data_o (0 whenever no beat is presented).
module floo_wide_link_tx #(
    parameter int unsigned FlitWidth = 512,
    parameter int unsigned PhysWidth = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [FlitWidth-1:0] data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [PhysWidth-1:0] data_o,
    output logic                 last_o
`ifdef FLOO_WIDE_LINK_TX_PARITY_EN
    ,
    output logic                 parity_o
`endif
);

    localparam int unsigned NumBeats = (FlitWidth + PhysWidth - 1) / PhysWidth;
    localparam int unsigned BeatCntW = (NumBeats > 1) ? $clog2(NumBeats) : 1;
    localparam int unsigned BufW     = NumBeats * PhysWidth;
    localparam logic [BeatCntW-1:0] LastBeat = BeatCntW'(NumBeats - 1);

    // Reject configurations with a beat wider than the flit or an empty beat.
    if (PhysWidth > FlitWidth || PhysWidth == 0) begin : g_bad_width
        $error("floo_wide_link_tx: need 1 <= PhysWidth <= FlitWidth");
    end

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e                r_state;
    logic [BeatCntW-1:0]   r_beat_cnt;
    logic [BufW-1:0]       r_buf;

    logic                  w_send;
    logic                  w_last;
    logic                  w_beat_hs;
    logic [BufW-1:0]       w_data_pad;

    // Flit zero-extended to a whole number of beats; pads the final beat.
    assign w_data_pad = BufW'(data_i);

    // Link-side decode, taken only from registered state.
    always_comb begin
        w_send    = (r_state == SEND);
        w_last    = w_send && (r_beat_cnt == LastBeat);
        w_beat_hs = w_send && ready_i;
    end

    // Output drive: beat data comes from the low end of the shifting buffer.
    always_comb begin
        valid_o = w_send;
        last_o  = w_last;
        data_o  = w_send ? r_buf[PhysWidth-1:0] : '0;
        // Upstream may hand over a flit while idle, or in the same cycle the
        // last beat of the current flit is taken by the peer.
        ready_o = (r_state == IDLE) || (w_last && ready_i);
    end

`ifdef FLOO_WIDE_LINK_TX_PARITY_EN
    // Even parity of the presented beat; data_o is zero when idle.
    always_comb begin
        parity_o = ^data_o;
    end
`endif

    // Serializer FSM with beat counter and flit buffer.
    // The buffer shifts down by one beat per non-last handshake, so the
    // current beat always sits in the low PhysWidth bits; this is equivalent
    // to indexing buffer[beat_cnt*PhysWidth +: PhysWidth] without a wide mux.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_buf      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_buf      <= w_data_pad;
                        r_beat_cnt <= '0;
                        r_state    <= SEND;
                    end
                end
                SEND: begin
                    if (w_beat_hs) begin
                        if (w_last) begin
                            if (valid_i) begin
                                r_buf      <= w_data_pad;
                                r_beat_cnt <= '0;
                            end else begin
                                r_state    <= IDLE;
                            end
                        end else begin
                            r_buf      <= r_buf >> PhysWidth;
                            r_beat_cnt <= r_beat_cnt + BeatCntW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // A stalled beat must stay on the link unchanged until it is taken.
    property p_stall_hold;
        @(posedge clk_i) disable iff (!rst_ni)
            (valid_o && !ready_i) |=> (valid_o && $stable(data_o) && $stable(last_o));
    endproperty
    a_stall_hold: assert property (p_stall_hold)
        else $error("floo_wide_link_tx: beat changed while stalled");

    // The beat counter never runs past the final beat.
    property p_cnt_bound;
        @(posedge clk_i) disable iff (!rst_ni) (r_beat_cnt <= LastBeat);
    endproperty
    a_cnt_bound: assert property (p_cnt_bound)
        else $error("floo_wide_link_tx: beat counter out of range");
`endif

endmodule

// File: tb/tb_floo_wide_link_tx.sv
// Bench for floo_wide_link_tx: two instances (512/128 -> 4 beats and
// 300/128 -> 3 padded beats) share valid_i/ready_i. A queue of expected
// beats per instance is the reference: an accepted flit is sliced into
// beats, a taken beat is popped from the front.
module tb_floo_wide_link_tx;

    typedef logic [128:0] beat_t; // {last, data}

    logic         clk;
    logic         rst_ni;
    logic         valid_i;
    logic         ready_i;
    logic [511:0] data_i_a;
    logic [299:0] data_i_b;
    logic         ready_o_a, valid_o_a, last_o_a;
    logic         ready_o_b, valid_o_b, last_o_b;
    logic [127:0] data_o_a, data_o_b;
`ifdef FLOO_WIDE_LINK_TX_PARITY_EN
    logic         parity_o_a, parity_o_b;
`endif

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    beat_t        qa[$];
    beat_t        qb[$];
    logic [511:0] mask_b;

    floo_wide_link_tx #(.FlitWidth(512), .PhysWidth(128)) u_dut_a (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o_a),
        .data_i  (data_i_a),
        .valid_o (valid_o_a),
        .ready_i (ready_i),
        .data_o  (data_o_a),
        .last_o  (last_o_a)
`ifdef FLOO_WIDE_LINK_TX_PARITY_EN
        ,
        .parity_o(parity_o_a)
`endif
    );

    floo_wide_link_tx #(.FlitWidth(300), .PhysWidth(128)) u_dut_b (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o_b),
        .data_i  (data_i_b),
        .valid_o (valid_o_b),
        .ready_i (ready_i),
        .data_o  (data_o_b),
        .last_o  (last_o_b)
`ifdef FLOO_WIDE_LINK_TX_PARITY_EN
        ,
        .parity_o(parity_o_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rand_flit();
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    // One cycle: drive at the falling edge, check against the model, advance
    // the model for the coming rising edge.
    task automatic step(input logic v, input logic [511:0] d, input logic r);
        logic         ev_a, ev_b, er_a, er_b, el_a, el_b;
        logic [127:0] ed_a, ed_b;
        logic [511:0] db;
        valid_i  = v;
        ready_i  = r;
        data_i_a = d;
        data_i_b = d[299:0];
        #1;
        ev_a = (qa.size() != 0);
        ev_b = (qb.size() != 0);
        ed_a = ev_a ? qa[0][127:0] : '0;
        ed_b = ev_b ? qb[0][127:0] : '0;
        el_a = ev_a ? qa[0][128] : 1'b0;
        el_b = ev_b ? qb[0][128] : 1'b0;
        er_a = !ev_a || (qa.size() == 1 && r);
        er_b = !ev_b || (qb.size() == 1 && r);
        check("a_valid", 512'(valid_o_a), 512'(ev_a));
        check("a_data",  512'(data_o_a),  512'(ed_a));
        check("a_last",  512'(last_o_a),  512'(el_a));
        check("a_ready", 512'(ready_o_a), 512'(er_a));
        check("b_valid", 512'(valid_o_b), 512'(ev_b));
        check("b_data",  512'(data_o_b),  512'(ed_b));
        check("b_last",  512'(last_o_b),  512'(el_b));
        check("b_ready", 512'(ready_o_b), 512'(er_b));
`ifdef FLOO_WIDE_LINK_TX_PARITY_EN
        check("a_parity", 512'(parity_o_a), 512'(^ed_a));
        check("b_parity", 512'(parity_o_b), 512'(^ed_b));
`endif
        if (ev_a && r) void'(qa.pop_front());
        if (ev_b && r) void'(qb.pop_front());
        if (v && er_a)
            for (int j = 0; j < 4; j++) qa.push_back({(j == 3), d[j*128 +: 128]});
        if (v && er_b) begin
            db = d & mask_b;
            for (int j = 0; j < 3; j++) qb.push_back({(j == 2), db[j*128 +: 128]});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset applied between edges; outputs must clear at once.
    task automatic do_reset();
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        #1;
        check("rst_a_valid", 512'(valid_o_a), 512'(0));
        check("rst_a_last",  512'(last_o_a),  512'(0));
        check("rst_a_data",  512'(data_o_a),  512'(0));
        check("rst_a_ready", 512'(ready_o_a), 512'(1));
        check("rst_b_valid", 512'(valid_o_b), 512'(0));
        check("rst_b_data",  512'(data_o_b),  512'(0));
        check("rst_b_ready", 512'(ready_o_b), 512'(1));
`ifdef FLOO_WIDE_LINK_TX_PARITY_EN
        check("rst_a_parity", 512'(parity_o_a), 512'(0));
`endif
        qa.delete();
        qb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [511:0] pat, f;
        int unsigned  guard;
        mask_b   = (512'(1) << 300) - 512'(1);
        rst_ni   = 1'b1;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        data_i_a = '0;
        data_i_b = '0;
        @(negedge clk);
        do_reset();

        // Byte-ramp flit with the link always ready.
        for (int i = 0; i < 64; i++) pat[i*8 +: 8] = 8'(i);
        step(1'b1, pat, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

        // Two flits back-to-back with valid held.
        step(1'b1, rand_flit(), 1'b1);
        f = rand_flit();
        guard = 0;
        while (qa.size() != 1 && guard < 10) begin
            step(1'b1, f, 1'b1);
            guard++;
        end
        check("b2b_bound", 512'(guard < 10), 512'(1));
        step(1'b1, f, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

        // Five-cycle stall on beat 1.
        step(1'b1, rand_flit(), 1'b1);
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

        // Reset while beat 2 is on the link, then a fresh flit.
        step(1'b1, rand_flit(), 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        do_reset();
        step(1'b1, pat, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

        // Random traffic with random backpressure.
        for (int i = 0; i < 800; i++)
            step(($urandom_range(0, 9) < 7), rand_flit(), ($urandom_range(0, 9) < 7));
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
